// File: rtl/rs_issue_select_pkg.sv
// Shared types for the reservation-station issue stage: LC-3b opcodes and entry index type.
package rs_issue_select_pkg;

    typedef enum logic [3:0] {
        OpBr  = 4'h0, OpAdd = 4'h1, OpLdb = 4'h2, OpStb = 4'h3,
        OpJsr = 4'h4, OpAnd = 4'h5, OpLdw = 4'h6, OpStw = 4'h7,
        OpRti = 4'h8, OpNot = 4'h9, OpLdi = 4'hA, OpSti = 4'hB,
        OpJmp = 4'hC, OpShf = 4'hD, OpLea = 4'hE, OpTrap = 4'hF
    } lc3b_opcode;

    localparam int unsigned RS_MAX_ENTRIES = 8;

    // Wide enough for the largest supported station; narrower stations zero-extend.
    typedef logic [$clog2(RS_MAX_ENTRIES)-1:0] rs_idx_t;

endpackage

// File: rtl/rs_issue_select_age_matrix.sv
// Allocation-order age matrix; picks the oldest ready entry as a one-hot select.
module rs_issue_select_age_matrix
    import rs_issue_select_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4
) (
    input  logic                   clk,
    input  logic                   i_flush,
    input  logic                   i_alloc_valid,
    input  rs_idx_t                i_alloc_idx,
    input  logic [NUM_ENTRIES-1:0] i_ready,
    output logic [NUM_ENTRIES-1:0] o_sel
);

    // r_older[i][j] = 1 means entry i was allocated before entry j.
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_older;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] w_older_d;
    logic [NUM_ENTRIES-1:0]                  w_blocked;

    always_comb begin
        w_older_d = r_older;
        if (i_alloc_valid) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (rs_idx_t'(i) == i_alloc_idx) begin
                        w_older_d[i][j] = 1'b0;
                    end else if (rs_idx_t'(j) == i_alloc_idx) begin
                        w_older_d[i][j] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_older <= '0;
        end else begin
            r_older <= w_older_d;
        end
    end

    // A pair with no recorded order (neither allocated since flush) resolves to the lower index.
    always_comb begin
        w_blocked = '0;
        o_sel     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j < i) begin
                    w_blocked[i] = w_blocked[i] | (i_ready[j] & ~r_older[i][j]);
                end else if (j > i) begin
                    w_blocked[i] = w_blocked[i] | (i_ready[j] & r_older[j][i]);
                end
            end
            o_sel[i] = i_ready[i] & ~w_blocked[i];
        end
    end

endmodule

// File: rtl/rs_issue_select_reg.sv
// Plain load/clear register used for each field of the issue output stage.
module rs_issue_select_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rs_issue_select.sv
// Issue stage for one functional unit: oldest-ready select from the reservation station,
// busy-clear strobe and a captured output register toward the FU.
module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned data_width  = 16,
    parameter int unsigned tag_width   = 3,
    localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                                  clk,
    input  logic                                  flush,
    input  logic                                  alloc_valid,
    input  logic [IDX_W-1:0]                      alloc_idx,
    input  logic [NUM_ENTRIES-1:0]                rs_busy,
    input  logic [NUM_ENTRIES-1:0]                rs_Vj_valid,
    input  logic [NUM_ENTRIES-1:0]                rs_Vk_valid,
    input  logic [NUM_ENTRIES-1:0][data_width-1:0] rs_Vj,
    input  logic [NUM_ENTRIES-1:0][data_width-1:0] rs_Vk,
    input  lc3b_opcode [NUM_ENTRIES-1:0]          rs_op,
    input  logic [NUM_ENTRIES-1:0][tag_width-1:0] rs_dest,
    output logic [NUM_ENTRIES-1:0]                clr_busy,
    output logic                                  fu_valid,
    input  logic                                  fu_ready,
    output lc3b_opcode                            fu_op,
    output logic [data_width-1:0]                 fu_a,
    output logic [data_width-1:0]                 fu_b,
    output logic [tag_width-1:0]                  fu_dest
);

    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_sel;
    logic                   w_can_issue;
    logic                   w_issue;
    logic [data_width-1:0]  w_sel_a;
    logic [data_width-1:0]  w_sel_b;
    logic [tag_width-1:0]   w_sel_dest;
    logic [3:0]             w_sel_op;
    logic [3:0]             w_fu_op_q;

    assign w_ready = rs_busy & rs_Vj_valid & rs_Vk_valid;

    rs_issue_select_age_matrix #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_age_matrix (
        .clk           (clk),
        .i_flush       (flush),
        .i_alloc_valid (alloc_valid),
        .i_alloc_idx   (rs_idx_t'(alloc_idx)),
        .i_ready       (w_ready),
        .o_sel         (w_sel)
    );

    assign w_can_issue = ~fu_valid | fu_ready;
    assign w_issue     = w_can_issue & (|w_sel) & ~flush;
    assign clr_busy    = w_issue ? w_sel : '0;

    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_dest = '0;
        w_sel_op   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_sel[i]) begin
                w_sel_a    = rs_Vj[i];
                w_sel_b    = rs_Vk[i];
                w_sel_dest = rs_dest[i];
                w_sel_op   = rs_op[i];
            end
        end
    end

    // fu_valid reloads whenever the stage is free or draining; it drops when nothing is selected.
    rs_issue_select_reg #(.WIDTH(1)) u_reg_valid (
        .clk    (clk),
        .i_clr  (flush),
        .i_load (w_can_issue),
        .i_d    (|w_sel),
        .o_q    (fu_valid)
    );

    rs_issue_select_reg #(.WIDTH(4)) u_reg_op (
        .clk    (clk),
        .i_clr  (flush),
        .i_load (w_issue),
        .i_d    (w_sel_op),
        .o_q    (w_fu_op_q)
    );

    rs_issue_select_reg #(.WIDTH(data_width)) u_reg_a (
        .clk    (clk),
        .i_clr  (flush),
        .i_load (w_issue),
        .i_d    (w_sel_a),
        .o_q    (fu_a)
    );

    rs_issue_select_reg #(.WIDTH(data_width)) u_reg_b (
        .clk    (clk),
        .i_clr  (flush),
        .i_load (w_issue),
        .i_d    (w_sel_b),
        .o_q    (fu_b)
    );

    rs_issue_select_reg #(.WIDTH(tag_width)) u_reg_dest (
        .clk    (clk),
        .i_clr  (flush),
        .i_load (w_issue),
        .i_d    (w_sel_dest),
        .o_q    (fu_dest)
    );

    assign fu_op = lc3b_opcode'(w_fu_op_q);

    // Dispatch must never overwrite a live entry.
    always_ff @(posedge clk) begin
        if (!flush && alloc_valid) begin
            assert (!rs_busy[alloc_idx]);
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
// Scoreboard bench for rs_issue_select: models the reservation station and checks issue order.
module tb_rs_issue_select;
    import rs_issue_select_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 3;

    logic                  clk = 1'b0;
    logic                  flush;
    logic                  alloc_valid;
    logic [1:0]            alloc_idx;
    logic [N-1:0]          rs_busy, rs_Vj_valid, rs_Vk_valid;
    logic [N-1:0][DW-1:0]  rs_Vj, rs_Vk;
    lc3b_opcode [N-1:0]    rs_op;
    logic [N-1:0][TW-1:0]  rs_dest;
    logic [N-1:0]          clr_busy;
    logic                  fu_valid, fu_ready;
    lc3b_opcode            fu_op;
    logic [DW-1:0]         fu_a, fu_b;
    logic [TW-1:0]         fu_dest;

    typedef struct packed {
        logic [TW-1:0] dest;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    op;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rs_issue_select #(
        .NUM_ENTRIES (N),
        .data_width  (DW),
        .tag_width   (TW)
    ) dut (
        .clk         (clk),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .rs_busy     (rs_busy),
        .rs_Vj_valid (rs_Vj_valid),
        .rs_Vk_valid (rs_Vk_valid),
        .rs_Vj       (rs_Vj),
        .rs_Vk       (rs_Vk),
        .rs_op       (rs_op),
        .rs_dest     (rs_dest),
        .clr_busy    (clr_busy),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_op       (fu_op),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_dest     (fu_dest)
    );

    // One clock: score any FU transfer, then apply busy-clear and allocation to the RS model.
    task automatic tick();
        logic [N-1:0] c;
        exp_t e, g;
        #1;
        c = clr_busy;
        if (flush) begin
            sb_q.delete();
        end else if (fu_valid && fu_ready) begin
            checks++;
            g.dest = fu_dest; g.a = fu_a; g.b = fu_b; g.op = fu_op;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: transfer dest=%0d with empty scoreboard", fu_dest);
            end else begin
                e = sb_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL sb_data: got dest=%0d a=%h b=%h op=%h, want dest=%0d a=%h b=%h op=%h",
                             g.dest, g.a, g.b, g.op, e.dest, e.a, e.b, e.op);
                end
            end
        end
        @(posedge clk);
        #1;
        rs_busy = rs_busy & ~c;
        if (alloc_valid) rs_busy[alloc_idx] = 1'b1;
        alloc_valid = 1'b0;
        #1;
    endtask

    task automatic set_entry(input int k, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                             input logic [TW-1:0] dest, input lc3b_opcode op,
                             input logic vjv, input logic vkv);
        rs_Vj[k] = vj; rs_Vk[k] = vk; rs_dest[k] = dest; rs_op[k] = op;
        rs_Vj_valid[k] = vjv; rs_Vk_valid[k] = vkv;
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.dest = rs_dest[k]; e.a = rs_Vj[k]; e.b = rs_Vk[k]; e.op = rs_op[k];
        sb_q.push_back(e);
    endtask

    task automatic alloc(input int k);
        alloc_valid = 1'b1;
        alloc_idx   = 2'(k);
        tick();
    endtask

    task automatic do_flush();
        flush   = 1'b1;
        rs_busy = '0;
        tick();
        flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_flush();
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", fu_valid); end
        checks++; if ({fu_a, fu_b, fu_dest} !== '0) begin errors++; $display("FAIL rst_fields: got %h/%h/%h want 0", fu_a, fu_b, fu_dest); end
        checks++; if (fu_op !== OpBr) begin errors++; $display("FAIL rst_op: got %h want 0", fu_op); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (fu_valid !== 1'b0 || clr_busy !== 4'b0000) begin
                errors++; $display("FAIL idle_%0d: got valid=%b clr=%b want 0/0000", i, fu_valid, clr_busy);
            end
            tick();
        end
    endtask

    task automatic test_age_order();
        do_flush();
        fu_ready = 1'b1;
        set_entry(2, 16'h2222, 16'h2020, 3'd2, OpAdd, 1'b1, 1'b0);
        set_entry(0, 16'h1000, 16'h0100, 3'd5, OpAnd, 1'b1, 1'b0);
        set_entry(3, 16'h3000, 16'h0300, 3'd7, OpShf, 1'b1, 1'b0);
        alloc(2); alloc(0); alloc(3);
        checks++; if (clr_busy !== 4'b0000) begin errors++; $display("FAIL age_notready: got %b want 0000", clr_busy); end
        rs_Vk_valid = 4'b1101;
        #1;
        checks++; if (clr_busy !== 4'b0100) begin errors++; $display("FAIL age_clr0: got %b want 0100", clr_busy); end
        push_exp(2); tick();
        checks++; if (clr_busy !== 4'b0001) begin errors++; $display("FAIL age_clr1: got %b want 0001", clr_busy); end
        checks++; if (fu_valid !== 1'b1 || fu_dest !== 3'd2) begin errors++; $display("FAIL age_dest0: got v=%b d=%0d want 1/2", fu_valid, fu_dest); end
        push_exp(0); tick();
        checks++; if (clr_busy !== 4'b1000) begin errors++; $display("FAIL age_clr2: got %b want 1000", clr_busy); end
        push_exp(3); tick();
        checks++; if (clr_busy !== 4'b0000 || fu_dest !== 3'd7) begin errors++; $display("FAIL age_last: got clr=%b d=%0d want 0000/7", clr_busy, fu_dest); end
        tick();
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL age_drain: got %b want 0", fu_valid); end
    endtask

    task automatic test_backpressure();
        do_flush();
        fu_ready = 1'b0;
        set_entry(1, 16'h1234, 16'h00FF, 3'd4, OpLdw, 1'b1, 1'b1);
        set_entry(2, 16'hAAAA, 16'h5555, 3'd6, OpStw, 1'b1, 1'b1);
        alloc(1);
        checks++; if (clr_busy !== 4'b0010) begin errors++; $display("FAIL bp_issue1: got %b want 0010", clr_busy); end
        push_exp(1);
        alloc(2);
        rs_Vj[1] = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fu_valid !== 1'b1 || fu_a !== 16'h1234 || fu_b !== 16'h00FF || clr_busy !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b a=%h b=%h clr=%b want 1/1234/00ff/0000",
                         i, fu_valid, fu_a, fu_b, clr_busy);
            end
            tick();
        end
        fu_ready = 1'b1;
        #1;
        checks++; if (clr_busy !== 4'b0100) begin errors++; $display("FAIL bp_release: got %b want 0100", clr_busy); end
        push_exp(2); tick();
        checks++; if (fu_a !== 16'hAAAA) begin errors++; $display("FAIL bp_next_a: got %h want aaaa", fu_a); end
        tick();
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", fu_valid); end
    endtask

    task automatic test_partial_ready();
        do_flush();
        fu_ready = 1'b1;
        set_entry(0, 16'h0B0B, 16'h0C0C, 3'd1, OpLdb, 1'b1, 1'b0);
        set_entry(3, 16'h3B3B, 16'h3C3C, 3'd3, OpJsr, 1'b1, 1'b1);
        alloc(0);
        checks++; if (clr_busy !== 4'b0000) begin errors++; $display("FAIL pr_wait: got %b want 0000", clr_busy); end
        alloc(3);
        checks++; if (clr_busy !== 4'b1000) begin errors++; $display("FAIL pr_young: got %b want 1000", clr_busy); end
        push_exp(3); tick();
        checks++; if (clr_busy !== 4'b0000 || fu_dest !== 3'd3) begin errors++; $display("FAIL pr_idle: got clr=%b d=%0d want 0000/3", clr_busy, fu_dest); end
        rs_Vk_valid[0] = 1'b1;
        #1;
        checks++; if (clr_busy !== 4'b0001) begin errors++; $display("FAIL pr_old: got %b want 0001", clr_busy); end
        push_exp(0); tick();
        checks++; if (fu_dest !== 3'd1) begin errors++; $display("FAIL pr_dest: got %0d want 1", fu_dest); end
        tick();
    endtask

    task automatic test_flush_mid();
        do_flush();
        fu_ready = 1'b0;
        set_entry(3, 16'h3333, 16'h0003, 3'd0, OpNot, 1'b1, 1'b0);
        set_entry(1, 16'h1111, 16'h0001, 3'd6, OpLea, 1'b1, 1'b0);
        set_entry(2, 16'h2121, 16'h0002, 3'd2, OpJmp, 1'b1, 1'b1);
        alloc(3); alloc(1); alloc(2);
        checks++; if (clr_busy !== 4'b0100) begin errors++; $display("FAIL fl_first: got %b want 0100", clr_busy); end
        push_exp(2); tick();
        rs_Vk_valid[3] = 1'b1; rs_Vk_valid[1] = 1'b1;
        fu_ready = 1'b1;
        #1;
        checks++; if (clr_busy !== 4'b1000) begin errors++; $display("FAIL fl_older: got %b want 1000", clr_busy); end
        flush = 1'b1;
        #1;
        checks++; if (clr_busy !== 4'b0000) begin errors++; $display("FAIL fl_clr: got %b want 0000", clr_busy); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", fu_valid); end
        checks++; if (clr_busy !== 4'b0010) begin errors++; $display("FAIL fl_tie: got %b want 0010", clr_busy); end
        push_exp(1); tick();
        checks++; if (clr_busy !== 4'b1000) begin errors++; $display("FAIL fl_next: got %b want 1000", clr_busy); end
        push_exp(3); tick();
        tick();
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL fl_drain: got %b want 0", fu_valid); end
    endtask

    task automatic test_alloc_issue();
        do_flush();
        fu_ready = 1'b1;
        set_entry(0, 16'h0A0A, 16'h00A0, 3'd3, OpRti, 1'b1, 1'b1);
        set_entry(1, 16'h1A1A, 16'h01A0, 3'd4, OpSti, 1'b1, 1'b0);
        alloc(0);
        checks++; if (clr_busy !== 4'b0001) begin errors++; $display("FAIL ai_issue0: got %b want 0001", clr_busy); end
        push_exp(0);
        alloc(1);
        checks++; if (fu_dest !== 3'd3 || clr_busy !== 4'b0000) begin errors++; $display("FAIL ai_after: got d=%0d clr=%b want 3/0000", fu_dest, clr_busy); end
        set_entry(0, 16'h0F0F, 16'h00F0, 3'd6, OpLdi, 1'b1, 1'b0);
        alloc(0);
        rs_Vk_valid[0] = 1'b1; rs_Vk_valid[1] = 1'b1;
        #1;
        checks++; if (clr_busy !== 4'b0010) begin errors++; $display("FAIL ai_oldest: got %b want 0010", clr_busy); end
        push_exp(1); tick();
        checks++; if (clr_busy !== 4'b0001) begin errors++; $display("FAIL ai_second: got %b want 0001", clr_busy); end
        push_exp(0); tick();
        tick();
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL ai_drain: got %b want 0", fu_valid); end
    endtask

    initial begin
        flush = 1'b1; alloc_valid = 1'b0; alloc_idx = '0; fu_ready = 1'b0;
        rs_busy = '0; rs_Vj_valid = '0; rs_Vk_valid = '0;
        rs_Vj = '0; rs_Vk = '0; rs_dest = '0;
        for (int i = 0; i < N; i++) rs_op[i] = OpBr;
        test_reset();
        test_age_order();
        test_backpressure();
        test_partial_ready();
        test_flush_mid();
        test_alloc_issue();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
